// File: rtl/dir_btn_if.sv
// dir_btn_if: pushbutton-in, direction/clear-out bundle between the board button and dir_btn_ctrl
//   btn     raw pushbutton level (asynchronous, may bounce)
//   up      count direction, 1 = up
//   clr_req one-cycle clear request on long press
//   db      debounced button level
interface dir_btn_if;
    logic btn;
    logic up;
    logic clr_req;
    logic db;
    modport master (output btn, input up, clr_req, db);
    modport slave (input btn, output up, clr_req, db);
endinterface

// File: rtl/dir_btn_ctrl.sv
// dir_btn_ctrl: debounced pushbutton to up/down direction toggle (short press) and clear request (long press)
//   clk  system clock, rising edge
//   clr  synchronous active-high reset
//   bus  dir_btn_if slave: btn in; up, clr_req, db out (all registered)
module dir_btn_ctrl #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 16
) (
    input logic      clk,
    input logic      clr,
    dir_btn_if.slave bus
);
    localparam int DW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
    state_t state_q, state_d;
    logic s1_q, s1_d, s2_q, s2_d, db_q, db_d, up_q, up_d, clr_req_q, clr_req_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    always_comb begin
        s1_d      = bus.btn;
        s2_d      = s1_q;
        db_d      = db_q;
        dcnt_d    = '0;
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        up_d      = up_q;
        clr_req_d = 1'b0;
        // any agreeing cycle leaves dcnt_d at zero, restarting the window
        if (s2_q != db_q) begin
            if (dcnt_q == DMAX) db_d = s2_q;
            else dcnt_d = dcnt_q + DW'(1);
        end
        case (state_q)
            IDLE: if (db_q) begin
                state_d = PRESS;
                hcnt_d  = '0;
            end
            // release wins over the hold-time check on the same edge
            PRESS: if (!db_q) begin
                state_d = IDLE;
                up_d    = ~up_q;
            end else if (hcnt_q == HMAX) begin
                state_d   = HELD;
                clr_req_d = 1'b1;
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
            HELD: state_d = db_q ? HELD : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            dcnt_q    <= '0;
            state_q   <= IDLE;
            hcnt_q    <= '0;
            up_q      <= 1'b0;
            clr_req_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            up_q      <= up_d;
            clr_req_q <= clr_req_d;
        end
    end
    assign bus.up      = up_q;
    assign bus.clr_req = clr_req_q;
    assign bus.db      = db_q;
endmodule

// File: tb/tb_dir_btn_ctrl.sv
// tb_dir_btn_ctrl: directed self-checking bench for dir_btn_ctrl at DB_CYCLES=4, HOLD_CYCLES=16
module tb_dir_btn_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int errors = 0;
    int checks = 0;
    dir_btn_if bus ();
    dir_btn_ctrl #(.DB_CYCLES(4), .HOLD_CYCLES(16)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );
    always #10 clk = ~clk;
    // advance n rising edges, landing 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        clr = 1'b1;
        bus.btn = 1'b0;
        tick(2);
        clr = 1'b0;
    endtask
    // btn high for n sampled edges, then low long enough for db and FSM to settle
    task automatic press(input int n);
        bus.btn = 1'b1;
        tick(n);
        bus.btn = 1'b0;
        tick(12);
    endtask
    task automatic test_reset();
        clr = 1'b1;
        bus.btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if ({bus.up, bus.clr_req, bus.db} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got up/clr_req/db=%b expected 000", i, {bus.up, bus.clr_req, bus.db});
            end
        end
        clr = 1'b0;
        tick(5);
        checks++;
        if (bus.db !== 1'b0) begin
            errors++;
            $display("FAIL reset_db_k4: got %b expected 0", bus.db);
        end
        tick(1);
        checks++;
        if (bus.db !== 1'b1) begin
            errors++;
            $display("FAIL reset_db_k5: got %b expected 1", bus.db);
        end
        bus.btn = 1'b0;
        tick(12);
    endtask
    task automatic test_bounce();
        logic [7:0] pat;
        do_reset();
        pat = 8'b0111_0111;
        for (int i = 0; i < 8; i++) begin
            bus.btn = pat[i];
            tick(1);
            checks++;
            if (bus.db !== 1'b0) begin
                errors++;
                $display("FAIL bounce_db cycle %0d: got %b expected 0", i, bus.db);
            end
        end
        bus.btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++;
            if ({bus.up, bus.clr_req, bus.db} !== 3'b000) begin
                errors++;
                $display("FAIL bounce_tail cycle %0d: got up/clr_req/db=%b expected 000", i, {bus.up, bus.clr_req, bus.db});
            end
        end
    endtask
    task automatic test_short_press();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            bus.btn = 1'b1;
            tick(5);
            checks++;
            if (bus.db !== 1'b0) begin
                errors++;
                $display("FAIL short_db_pre p%0d: got %b expected 0", p, bus.db);
            end
            tick(1);
            checks++;
            if (bus.db !== 1'b1) begin
                errors++;
                $display("FAIL short_db_rise p%0d: got %b expected 1", p, bus.db);
            end
            tick(4);
            bus.btn = 1'b0;
            tick(5);
            checks++;
            if (bus.db !== 1'b1) begin
                errors++;
                $display("FAIL short_db_hold p%0d: got %b expected 1", p, bus.db);
            end
            tick(1);
            checks++;
            if (bus.db !== 1'b0 || bus.up !== p[0]) begin
                errors++;
                $display("FAIL short_fall p%0d: got db=%b up=%b expected db=0 up=%b", p, bus.db, bus.up, p[0]);
            end
            tick(1);
            checks++;
            if (bus.up !== ~p[0] || bus.clr_req !== 1'b0) begin
                errors++;
                $display("FAIL short_toggle p%0d: got up=%b clr_req=%b expected up=%b clr_req=0", p, bus.up, bus.clr_req, ~p[0]);
            end
            tick(6);
        end
    endtask
    task automatic test_long_press();
        do_reset();
        bus.btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            checks++;
            if (bus.clr_req !== (i == 22)) begin
                errors++;
                $display("FAIL long_clr_req edge k+%0d: got %b expected %b", i, bus.clr_req, (i == 22));
            end
        end
        bus.btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (bus.clr_req !== 1'b0 || bus.up !== 1'b0) begin
                errors++;
                $display("FAIL long_release cycle %0d: got clr_req=%b up=%b expected 0 0", i, bus.clr_req, bus.up);
            end
        end
    endtask
    task automatic test_hold_boundary();
        int pulses;
        do_reset();
        for (int n = 16; n <= 17; n++) begin
            pulses = 0;
            bus.btn = 1'b1;
            for (int i = 0; i < n + 14; i++) begin
                if (i == n) bus.btn = 1'b0;
                tick(1);
                if (bus.clr_req === 1'b1) pulses++;
            end
            checks++;
            if (pulses !== n - 16) begin
                errors++;
                $display("FAIL hold_%0d_pulses: got %0d expected %0d", n, pulses, n - 16);
            end
            checks++;
            if (bus.up !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d_up: got %b expected 1", n, bus.up);
            end
        end
    endtask
    task automatic test_reset_mid_press();
        do_reset();
        press(10);
        checks++;
        if (bus.up !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup_up: got %b expected 1", bus.up);
        end
        bus.btn = 1'b1;
        tick(9);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        checks++;
        if ({bus.up, bus.clr_req, bus.db} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_outs: got up/clr_req/db=%b expected 000", {bus.up, bus.clr_req, bus.db});
        end
        tick(5);
        checks++;
        if (bus.db !== 1'b0) begin
            errors++;
            $display("FAIL mid_db_pre: got %b expected 0", bus.db);
        end
        tick(1);
        checks++;
        if (bus.db !== 1'b1) begin
            errors++;
            $display("FAIL mid_db_rise: got %b expected 1", bus.db);
        end
        for (int i = 16; i <= 33; i++) begin
            tick(1);
            checks++;
            if (bus.clr_req !== (i == 32)) begin
                errors++;
                $display("FAIL mid_clr_req edge k+%0d: got %b expected %b", i, bus.clr_req, (i == 32));
            end
        end
        bus.btn = 1'b0;
        tick(12);
        checks++;
        if (bus.up !== 1'b0) begin
            errors++;
            $display("FAIL mid_up_final: got %b expected 0", bus.up);
        end
    endtask
    initial begin
        bus.btn = 1'b0;
        test_reset();
        test_bounce();
        test_short_press();
        test_long_press();
        test_hold_boundary();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
